// File: rtl/kbd_scan_ctrl_if.sv
// Keypad scanner bus: row sense in, column drive and accepted-key reporting out.
// The scanner itself uses the slave modport; the keypad/consumer side uses master.
interface kbd_scan_ctrl_if;
  logic [3:0] fila;
  logic [3:0] col;
  logic [4:0] key_code;
  logic       key_valid;
  logic [1:0] key_count;
  logic       busy;

  modport master (
    output fila,
    input  col, key_code, key_valid, key_count, busy
  );

  modport slave (
    input  fila,
    output col, key_code, key_valid, key_count, busy
  );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// 4x4 keypad scanner: rotates one-hot column drive, debounces press/release, reports key codes.
// Optional auto-repeat of a held key is enabled by defining KBD_AUTOREPEAT_EN.
module kbd_scan_ctrl #(
  parameter int SCAN_DIV   = 4,
  parameter int DEB_CNT    = 3,
  parameter int REPEAT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  kbd_scan_ctrl_if.slave  kbd
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    col_reg, col_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    row_reg, row_next;
  logic [3:0]    pend_code_reg, pend_code_next;
  logic [4:0]    key_code_reg, key_code_next;
  logic          key_valid_reg, key_valid_next;
  logic [1:0]    key_count_reg, key_count_next;

  logic [1:0]    row_idx, col_idx;
  logic          fila_one_hot;
  logic [3:0]    col_rot;

`ifdef KBD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] rep_reg, rep_next;
`else
  // REPEAT_CYC has no effect when auto-repeat is compiled out.
  logic unused_repeat_cyc;
  assign unused_repeat_cyc = ^REPEAT_CYC;
`endif

  assign fila_one_hot = (kbd.fila != 4'd0) && ((kbd.fila & (kbd.fila - 4'd1)) == 4'd0);
  assign col_rot      = {col_reg[2:0], col_reg[3]};

  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (kbd.fila[i]) row_idx = 2'(i);
      if (col_reg[i])  col_idx = 2'(i);
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    dwell_next     = dwell_reg;
    cnt_next       = cnt_reg;
    row_next       = row_reg;
    pend_code_next = pend_code_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_count_next = key_count_reg;
`ifdef KBD_AUTOREPEAT_EN
    rep_next       = rep_reg;
`endif

    case (state_reg)
      SCAN: begin
        // Rows are only looked at on the last dwell cycle so the column drive has settled.
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          if (fila_one_hot) begin
            row_next       = kbd.fila;
            pend_code_next = {row_idx, col_idx};
            cnt_next       = '0;
            state_next     = DEBOUNCE;
          end else begin
            col_next = col_rot;
          end
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (kbd.fila == row_reg) begin
          if (cnt_reg == CNT_LAST) state_next = PRESSED;
          else                     cnt_next   = cnt_reg + 1'b1;
        end else begin
          state_next = SCAN;
          col_next   = col_rot;
          dwell_next = '0;
        end
      end

      PRESSED: begin
        key_valid_next = 1'b1;
        key_code_next  = {1'b0, pend_code_reg};
        key_count_next = key_count_reg + 1'b1;
        cnt_next       = '0;
        state_next     = RELEASE;
`ifdef KBD_AUTOREPEAT_EN
        rep_next       = '0;
`endif
      end

      RELEASE: begin
        if (kbd.fila == 4'd0) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = SCAN;
            col_next   = col_rot;
            dwell_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
`ifdef KBD_AUTOREPEAT_EN
        if (kbd.fila == row_reg) begin
          if (rep_reg == REP_LAST) begin
            rep_next       = '0;
            key_valid_next = 1'b1;
            key_count_next = key_count_reg + 1'b1;
          end else begin
            rep_next = rep_reg + 1'b1;
          end
        end else begin
          rep_next = '0;
        end
`endif
      end

      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SCAN;
      col_reg       <= 4'b0001;
      dwell_reg     <= '0;
      cnt_reg       <= '0;
      row_reg       <= '0;
      pend_code_reg <= '0;
      key_code_reg  <= 5'h1F;
      key_valid_reg <= 1'b0;
      key_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      dwell_reg     <= dwell_next;
      cnt_reg       <= cnt_next;
      row_reg       <= row_next;
      pend_code_reg <= pend_code_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_count_reg <= key_count_next;
    end
  end

`ifdef KBD_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) rep_reg <= '0;
    else     rep_reg <= rep_next;
  end
`endif

  assign kbd.col       = col_reg;
  assign kbd.key_code  = key_code_reg;
  assign kbd.key_valid = key_valid_reg;
  assign kbd.key_count = key_count_reg;
  assign kbd.busy      = (state_reg != SCAN);

endmodule

// File: doc/kbd_scan_ctrl.md
KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 The block SHALL provide parameters: SCAN_DIV, default 4, clock cycles each column stays driven; DEB_CNT, default 3, consecutive stable cycles required for press and release; REPEAT_CYC, default 16, auto-repeat period in cycles.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 fila  input  4  keypad row sense; bit n high means row n is active.
REQ-005 col  output  4  one-hot column drive; bit n drives column n.
REQ-006 key_code  output  5  last accepted key, row_idx*4+col_idx (0..15); 5'h1F means no key accepted since reset.
REQ-007 key_valid  output  1  one-cycle pulse marking a newly accepted key.
REQ-008 key_count  output  2  count of accepted keys modulo 4, used as the display digit position.
REQ-009 busy  output  1  high in every state except SCAN.

Function
REQ-010 The block SHALL use four states: SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-011 In SCAN, a dwell counter SHALL count 0..SCAN_DIV-1; on wrap, col SHALL rotate 0001->0010->0100->1000->0001.
REQ-012 In SCAN, fila SHALL be sampled only when dwell equals SCAN_DIV-1, to allow settling.
REQ-013 At a sample, if fila is exactly one-hot, the block SHALL latch row index, column index and fila, freeze col, and enter DEBOUNCE with the debounce counter at 0.
REQ-014 At a sample, if fila is zero or has two or more bits set, the block SHALL treat it as no press and continue scanning.
REQ-015 In DEBOUNCE, each cycle with fila equal to the latched row SHALL increment the counter; when the counter reaches DEB_CNT-1 with a match, the next state SHALL be PRESSED.
REQ-016 In DEBOUNCE, any mismatch SHALL return to SCAN with col advanced to the next column and dwell reset to 0.
REQ-017 PRESSED SHALL last exactly one cycle, during which the block SHALL:
- assert key_valid;
- update key_code to the latched code;
- increment key_count, wrapping 3->0;
- then go to RELEASE.
REQ-018 In RELEASE, col SHALL remain frozen; DEB_CNT consecutive cycles of fila==0 SHALL return to SCAN at the next column; any nonzero fila SHALL restart the release count.
REQ-019 key_valid SHALL go high exactly DEB_CNT+1 cycles after the sampling edge of a clean press.
REQ-020 Outside PRESSED (and outside repeat pulses, REQ-024), key_valid SHALL be 0.
REQ-021 key_code and key_count SHALL hold their values between pulses.

Reset
REQ-022 When rst is high at an edge, rst SHALL override all other activity in every state; on the next cycle the outputs SHALL be:
- state SCAN, col 4'b0001;
- dwell, debounce and repeat counters 0;
- key_valid 0, key_code 5'h1F, key_count 0, busy 0.
REQ-023 A reset arriving during DEBOUNCE or RELEASE SHALL discard the pending key, and SHALL NOT produce a key_valid pulse.

Configuration
REQ-024 With macro KBD_AUTOREPEAT_EN defined, the block SHALL behave as follows in RELEASE while fila still equals the latched row:
- a repeat counter counts cycles;
- every REPEAT_CYC cycles the block pulses key_valid for one cycle with the same key_code and increments key_count;
- the counter restarts on any fila mismatch.
REQ-025 Without KBD_AUTOREPEAT_EN, the repeat counter SHALL not exist, and a held key SHALL produce exactly one key_valid pulse.

Verification
REQ-026 Reset: rst=1 for 1 cycle, then fila=0 -> col=0001, key_code=1F, key_valid=0, key_count=0, busy=0.
REQ-027 Idle scan, defaults: fila=0 -> col changes every 4 cycles: 0001, 0010, 0100, 1000, 0001.
REQ-028 Clean press: fila=0010 held from the cycle col becomes 0100 -> key_valid pulses once, 4 cycles after the sample edge, with key_code=6 and key_count=1.
  - Releasing for 3 cycles -> col=1000 and busy=0.
REQ-029 Bounce and invalid input:
  - fila=0001 for 1 cycle at the sample, then 0 -> no pulse, scan resumes at the next column.
  - fila=0011 -> no state change.
REQ-030 Wrap and reset:
  - four clean presses -> key_count goes 1, 2, 3, 0.
  - rst asserted in DEBOUNCE -> no pulse, and REQ-022 values on the next cycle.
REQ-031 Held key for 50 cycles after the pulse:
  - macro off -> 1 pulse total.
  - KBD_AUTOREPEAT_EN -> 1 pulse plus 3 repeats at 16-cycle spacing, with key_count advancing by 4 in total.
